// File: rtl/fine_gain_saturator.sv
// fine_gain_saturator
//   Final stage ahead of the DAC: applies a fractional fine gain (0x8000 = 1.0),
//   scales by a soft enable/disable amplitude ramp, then clamps to the DAC word
//   width. Clipped valid samples are flagged and counted (sticky, non-wrapping).
//   Four register stages, valid travels with data, no back-pressure.
//   Optional build macro FINE_GAIN_SATURATOR_ROUND_EN: round half up before the
//   final width reduction (saturation then judges the rounded value).
module fine_gain_saturator #(
   parameter int IN_WIDTH   = 16,
   parameter int OUT_WIDTH  = 14,
   parameter int GAIN_WIDTH = 16,
   parameter int RAMP_SHIFT = 10,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [IN_WIDTH-1:0]   data_i,
   input  logic                  valid_i,
   input  logic [GAIN_WIDTH-1:0] gain_i,
   input  logic                  enable_i,
   input  logic                  clr_cnt_i,
   output logic [OUT_WIDTH-1:0]  data_o,
   output logic                  valid_o,
   output logic                  sat_o,
   output logic [CNT_WIDTH-1:0]  sat_cnt_o,
   output logic [1:0]            state_o
);

   // Datapath widths
   localparam int PW   = IN_WIDTH + GAIN_WIDTH + 1;  // data * {0,gain}
   localparam int S2W  = IN_WIDTH + 2;               // gain-scaled sample
   localparam int RW   = RAMP_SHIFT + 1;             // ramp level 0..2^RAMP_SHIFT
   localparam int QW   = S2W + RW + 1;               // sample * {0,r}
   localparam int SW   = S2W + 1;                    // headroom for rounding
   localparam int DROP = IN_WIDTH - OUT_WIDTH;

   localparam logic [RW-1:0] RAMP_MAX = {1'b1, {RAMP_SHIFT{1'b0}}};
   localparam logic [RW-1:0] RAMP_ONE = {{RAMP_SHIFT{1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (OUT_WIDTH - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_LO = SW'(-(1 << (OUT_WIDTH - 1)));

   typedef enum logic [1:0] {
      ST_OFF       = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_ON        = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } state_t;

   state_t                      r_state;
   logic [RW-1:0]               r_ramp;

   logic signed [IN_WIDTH-1:0]  r_s1_data;
   logic [GAIN_WIDTH-1:0]       r_s1_gain;
   logic                        r_s1_valid;
   logic signed [S2W-1:0]       r_s2_data;
   logic                        r_s2_valid;
   logic signed [S2W-1:0]       r_s3_data;
   logic                        r_s3_valid;
   logic [OUT_WIDTH-1:0]        r_data;
   logic                        r_valid;
   logic                        r_sat;
   logic [CNT_WIDTH-1:0]        r_sat_cnt;

   logic signed [PW-1:0]        w_gain_prod;
   logic signed [QW-1:0]        w_ramp_prod;
   logic signed [SW-1:0]        w_q_adj;
   logic signed [SW-1:0]        w_s;
   logic                        w_clip;
   logic [OUT_WIDTH-1:0]        w_clamped;

   // Both operands are widened to the product width before multiplying so the
   // signed product is exact; the gain gets a zero MSB to stay non-negative.
   assign w_gain_prod = PW'(r_s1_data) * PW'($signed({1'b0, r_s1_gain}));
   assign w_ramp_prod = QW'(r_s2_data) * QW'($signed({1'b0, r_ramp}));

`ifdef FINE_GAIN_SATURATOR_ROUND_EN
   localparam logic signed [SW-1:0] RND_HALF = SW'(1 << (DROP - 1));
   assign w_q_adj = SW'(r_s3_data) + RND_HALF;
`else
   assign w_q_adj = SW'(r_s3_data);
`endif

   assign w_s = w_q_adj >>> DROP;

   // Clamp the reduced sample to the signed DAC range and note whether it clipped
   always_comb begin
      w_clip    = 1'b0;
      w_clamped = w_s[OUT_WIDTH-1:0];
      if (w_s > SAT_HI) begin
         w_clip    = 1'b1;
         w_clamped = SAT_HI[OUT_WIDTH-1:0];
      end else if (w_s < SAT_LO) begin
         w_clip    = 1'b1;
         w_clamped = SAT_LO[OUT_WIDTH-1:0];
      end
   end

   // Ramp FSM: one level step per clock; reversals continue from the current level
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= ST_OFF;
         r_ramp  <= '0;
      end else begin
         case (r_state)
            ST_OFF: begin
               r_ramp <= '0;
               if (enable_i) r_state <= ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
               if (!enable_i) begin
                  r_state <= ST_RAMP_DOWN;
               end else if (r_ramp >= RAMP_MAX - RAMP_ONE) begin
                  r_ramp  <= RAMP_MAX;
                  r_state <= ST_ON;
               end else begin
                  r_ramp <= r_ramp + RAMP_ONE;
               end
            end
            ST_ON: begin
               r_ramp <= RAMP_MAX;
               if (!enable_i) r_state <= ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
               if (enable_i) begin
                  r_state <= ST_RAMP_UP;
               end else if (r_ramp <= RAMP_ONE) begin
                  r_ramp  <= '0;
                  r_state <= ST_OFF;
               end else begin
                  r_ramp <= r_ramp - RAMP_ONE;
               end
            end
            default: begin
               r_state <= ST_OFF;
               r_ramp  <= '0;
            end
         endcase
      end
   end

   // Sample pipeline: capture, fine gain, ramp scaling, clamp/flag
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_s1_data  <= '0;
         r_s1_gain  <= '0;
         r_s1_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_valid <= 1'b0;
         r_s3_data  <= '0;
         r_s3_valid <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_sat      <= 1'b0;
      end else begin
         r_s1_data  <= $signed(data_i);
         r_s1_gain  <= gain_i;
         r_s1_valid <= valid_i;
         // Gain product fits S2W bits after dropping the fractional bits
         r_s2_data  <= S2W'(w_gain_prod >>> (GAIN_WIDTH - 1));
         r_s2_valid <= r_s1_valid;
         // r <= 2^RAMP_SHIFT, so the scaled sample never grows past S2W bits
         r_s3_data  <= S2W'(w_ramp_prod >>> RAMP_SHIFT);
         r_s3_valid <= r_s2_valid;
         r_data     <= w_clamped;
         r_valid    <= r_s3_valid;
         r_sat      <= r_s3_valid & w_clip;
      end
   end

   // Clip counter: moves together with sat_o, saturates at all-ones, clear has priority
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_sat_cnt <= '0;
      end else if (clr_cnt_i) begin
         r_sat_cnt <= '0;
      end else if (r_s3_valid && w_clip && (r_sat_cnt != {CNT_WIDTH{1'b1}})) begin
         r_sat_cnt <= r_sat_cnt + CNT_ONE;
      end
   end

   assign data_o    = r_data;
   assign valid_o   = r_valid;
   assign sat_o     = r_sat;
   assign sat_cnt_o = r_sat_cnt;
   assign state_o   = r_state;

endmodule

// File: tb/tb_fine_gain_saturator.sv
// Bench for fine_gain_saturator (RAMP_SHIFT=4, 4-bit counter so saturation is reachable).
// A cycle-level reference model (plain integer arithmetic on a queue of samples)
// is compared every cycle; directed steps add hand-computed literal checks.
`timescale 1ns/1ps
module tb_fine_gain_saturator;
   localparam int IW   = 16;
   localparam int OW   = 14;
   localparam int GW   = 16;
   localparam int RS   = 4;
   localparam int CW   = 4;
   localparam int RMAX = 1 << RS;

   logic           clk_i = 1'b0;
   logic           rstn_i = 1'b0;
   logic [IW-1:0]  data_i = '0;
   logic           valid_i = 1'b0;
   logic [GW-1:0]  gain_i = '0;
   logic           enable_i = 1'b0;
   logic           clr_cnt_i = 1'b0;
   logic [OW-1:0]  data_o;
   logic           valid_o;
   logic           sat_o;
   logic [CW-1:0]  sat_cnt_o;
   logic [1:0]     state_o;

   fine_gain_saturator #(
      .IN_WIDTH(IW), .OUT_WIDTH(OW), .GAIN_WIDTH(GW), .RAMP_SHIFT(RS), .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .data_i(data_i), .valid_i(valid_i),
      .gain_i(gain_i), .enable_i(enable_i), .clr_cnt_i(clr_cnt_i),
      .data_o(data_o), .valid_o(valid_o), .sat_o(sat_o),
      .sat_cnt_o(sat_cnt_o), .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      longint d;
      longint g;
      bit     v;
   } smp_t;

   smp_t   q_in[$];
   int     m_r = 0;         // ramp level now
   int     m_r_prev = 0;    // ramp level one edge ago
   int     m_state = 0;
   int     m_cnt = 0;
   longint exp_data = 0;
   bit     exp_valid = 0;
   bit     exp_sat = 0;

   function automatic longint model_val(input longint d, input longint g,
                                        input int r, output bit clip);
      longint p, q, s;
      p = (d * g) >>> (GW - 1);        // floor(d*g / 2^15)
      q = (p * r) >>> RS;              // floor(p*r / 2^RS)
`ifdef FINE_GAIN_SATURATOR_ROUND_EN
      q = q + (1 << (IW - OW - 1));
`endif
      s = q >>> (IW - OW);
      clip = 1'b0;
      if (s > (1 << (OW - 1)) - 1) begin
         s = (1 << (OW - 1)) - 1;
         clip = 1'b1;
      end else if (s < -(1 << (OW - 1))) begin
         s = -(1 << (OW - 1));
         clip = 1'b1;
      end
      return s;
   endfunction

   initial begin
      smp_t ns, old;
      bit   clip;
      forever begin
         @(posedge clk_i);
         if (!rstn_i) begin
            q_in.delete();
            m_r = 0; m_r_prev = 0; m_state = 0; m_cnt = 0;
            exp_data = 0; exp_valid = 0; exp_sat = 0;
         end else begin
            ns.d = longint'($signed(data_i));
            ns.g = longint'(gain_i);
            ns.v = valid_i;
            q_in.push_back(ns);
            if (q_in.size() > 3) begin
               old = q_in.pop_front();
               // sample sampled 3 edges ago met the ramp level of one edge ago
               exp_data  = model_val(old.d, old.g, m_r_prev, clip);
               exp_valid = old.v;
               exp_sat   = old.v && clip;
            end else begin
               exp_data = 0; exp_valid = 0; exp_sat = 0;
            end
            if (clr_cnt_i) m_cnt = 0;
            else if (exp_sat && m_cnt < (1 << CW) - 1) m_cnt++;
            m_r_prev = m_r;
            case (m_state)
               0: if (enable_i) m_state = 1;
               1: if (!enable_i) m_state = 3;
                  else begin
                     m_r++;
                     if (m_r >= RMAX) begin m_r = RMAX; m_state = 2; end
                  end
               2: if (!enable_i) m_state = 3;
               default:
                  if (enable_i) m_state = 1;
                  else begin
                     if (m_r > 0) m_r--;
                     if (m_r == 0) m_state = 0;
                  end
            endcase
         end
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk_i);
         chk("cmp_data",  $signed(data_o), exp_data);
         chk("cmp_valid", valid_o, exp_valid);
         chk("cmp_sat",   sat_o, exp_sat);
         chk("cmp_cnt",   sat_cnt_o, m_cnt);
         chk("cmp_state", state_o, m_state);
      end
   end

   // ---------------- directed stimulus ----------------
   localparam logic [15:0] D_NOM = 16'h1000, G_NOM = 16'h8000;
   localparam logic [15:0] D_POS = 16'h7FFF, D_NEG = 16'h8000, G_BIG = 16'hFFFF;

   task automatic step(input bit en, input bit v, input logic [15:0] d,
                       input logic [15:0] g, input bit clr);
      enable_i = en; valid_i = v; data_i = d; gain_i = g; clr_cnt_i = clr;
      @(negedge clk_i);
      $display("step en=%0d v=%0d d=%h g=%h clr=%0d -> data_o=%0d valid=%0d sat=%0d cnt=%0d st=%0d",
               en, v, d, g, clr, $signed(data_o), valid_o, sat_o, sat_cnt_o, state_o);
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk_i);
      chk("rst_data",  $signed(data_o), 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_sat",   sat_o, 0);
      chk("rst_cnt",   sat_cnt_o, 0);
      chk("rst_state", state_o, 0);
      rstn_i = 1'b1;

      // Ramp up with nominal samples; output = 64*r
      k = 0;
      while (k < 40 && state_o != 2'd2) begin
         step(1, 1, D_NOM, G_NOM, 0);
         k++;
         if (k == 1)  chk("ramp_start_state", state_o, 1);
         if (k == 11) chk("mid_ramp_r8", $signed(data_o), 512);
      end
      chk("ramp_up_cycles", k, 17);
      repeat (3) step(1, 1, D_NOM, G_NOM, 0);
      chk("nominal_data",  $signed(data_o), 1024);
      chk("nominal_sat",   sat_o, 0);
      chk("nominal_valid", valid_o, 1);

      // Positive and negative clip
      step(1, 1, D_POS, G_BIG, 0);
      step(1, 1, D_NEG, G_BIG, 0);
      step(1, 1, D_NOM, G_NOM, 0);
      step(1, 1, D_NOM, G_NOM, 0);
      chk("pos_clip_data", $signed(data_o), 8191);
      chk("pos_clip_sat",  sat_o, 1);
      chk("pos_clip_cnt",  sat_cnt_o, 1);
      step(1, 1, D_NOM, G_NOM, 0);
      chk("neg_clip_data", $signed(data_o), -8192);
      chk("neg_clip_sat",  sat_o, 1);
      chk("neg_clip_cnt",  sat_cnt_o, 2);
      step(1, 1, D_NOM, G_NOM, 0);
      chk("after_clip_sat", sat_o, 0);

      // Invalid sample clips silently
      step(1, 0, D_POS, G_BIG, 0);
      repeat (3) step(1, 1, D_NOM, G_NOM, 0);
      chk("inv_clip_data",  $signed(data_o), 8191);
      chk("inv_clip_valid", valid_o, 0);
      chk("inv_clip_sat",   sat_o, 0);
      chk("inv_clip_cnt",   sat_cnt_o, 2);

      // Clear coinciding with a counted clip
      step(1, 1, D_POS, G_BIG, 0);
      step(1, 1, D_NOM, G_NOM, 0);
      step(1, 1, D_NOM, G_NOM, 0);
      step(1, 1, D_NOM, G_NOM, 1);
      chk("clr_prio_sat", sat_o, 1);
      chk("clr_prio_cnt", sat_cnt_o, 0);
      step(1, 1, D_NOM, G_NOM, 0);

      // Drive the counter to all-ones and beyond
      repeat (17) step(1, 1, D_POS, G_BIG, 0);
      repeat (3) step(1, 1, D_NOM, G_NOM, 0);
      chk("cnt_stick_sat", sat_o, 1);
      chk("cnt_stick_cnt", sat_cnt_o, 15);
      step(1, 1, D_NOM, G_NOM, 0);
      chk("cnt_stick_hold", sat_cnt_o, 15);

      // Full ramp down to OFF
      k = 0;
      while (k < 40 && state_o != 2'd0) begin
         step(0, 1, D_NOM, G_NOM, 0);
         k++;
      end
      chk("ramp_down_cycles", k, 17);
      repeat (3) step(0, 1, D_NOM, G_NOM, 0);
      chk("off_data",  $signed(data_o), 0);
      chk("off_valid", valid_o, 1);

      // Reversal during ramp-up at r=5
      repeat (6) step(1, 1, D_NOM, G_NOM, 0);
      chk("rev1_up_state", state_o, 1);
      step(0, 1, D_NOM, G_NOM, 0);
      chk("rev1_down_state", state_o, 3);
      for (int i = 1; i <= 5; i++) begin
         step(0, 1, D_NOM, G_NOM, 0);
         chk("rev1_down_walk", state_o, (i < 5) ? 3 : 0);
         if (i == 1) chk("rev1_r5_data", $signed(data_o), 320);
      end

      // Reversal during ramp-down at r=3
      repeat (5) step(1, 1, D_NOM, G_NOM, 0);
      chk("rev2_up_state", state_o, 1);
      step(0, 1, D_NOM, G_NOM, 0);
      chk("rev2_down_a", state_o, 3);
      step(0, 1, D_NOM, G_NOM, 0);
      chk("rev2_down_b", state_o, 3);
      step(1, 1, D_NOM, G_NOM, 0);
      chk("rev2_up_again", state_o, 1);
      step(1, 1, D_NOM, G_NOM, 0);
      step(1, 1, D_NOM, G_NOM, 0);
      chk("rev2_r3_data", $signed(data_o), 192);
      step(1, 1, D_NOM, G_NOM, 0);
      chk("rev2_r4_data", $signed(data_o), 256);

      // Reset with samples in flight
      repeat (3) step(1, 1, D_NOM, G_NOM, 0);
      chk("pre_reset_valid", valid_o, 1);
      #2 rstn_i = 1'b0;
      #1;
      chk("async_rst_data",  $signed(data_o), 0);
      chk("async_rst_valid", valid_o, 0);
      chk("async_rst_sat",   sat_o, 0);
      chk("async_rst_cnt",   sat_cnt_o, 0);
      chk("async_rst_state", state_o, 0);
      repeat (2) @(negedge clk_i);
      rstn_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 16'h0000, 16'h0000, 0);
         chk("post_rst_valid", valid_o, 0);
         chk("post_rst_state", state_o, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
